// File: rtl/quan_param_sched.sv
// Parameter scheduler for the quan2uint8 requantizer: per-channel parameter table,
// channel/pixel sequencing of the accumulator stream and one registered output stage.
module quan_param_sched #(
   parameter int unsigned CH_MAX = 16,
   parameter int unsigned CH_AW  = 4,
   parameter int unsigned PIX_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [CH_AW-1:0]   cfg_addr,
   input  logic [31:0]        cfg_m0,
   input  logic [5:0]         cfg_index,
   input  logic [7:0]         cfg_zw,
   input  logic [7:0]         cfg_z3,
   input  logic               start,
   input  logic [CH_AW:0]     num_ch,
   input  logic [PIX_W-1:0]   num_pix,
   input  logic               acc_valid,
   input  logic [31:0]        acc_data,
   input  logic               acc_if_sum,
   output logic               acc_ready,
   output logic               q_valid,
   output logic [31:0]        q_serial32,
   output logic               q_if_sum,
   output logic [31:0]        q_M0,
   output logic [5:0]         q_index,
   output logic [7:0]         q_z_of_weight,
   output logic [7:0]         q_z3,
   output logic               busy,
   output logic               done
);

   localparam int unsigned NCH_W = CH_AW + 1;

   typedef struct packed {
      logic [31:0] m0;
      logic [5:0]  index;
      logic [7:0]  zw;
      logic [7:0]  z3;
   } param_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CH_AW-1:0]   ch_cnt_q, ch_cnt_d;
   logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [NCH_W-1:0]   num_ch_q, num_ch_d;
   logic [PIX_W-1:0]   num_pix_q, num_pix_d;
   logic               beat;
   logic               ch_last;
   logic               pix_last;
   logic               cfg_hit;
   param_t             table_q [CH_MAX];
   param_t             entry_cur;

   assign ch_last   = (NCH_W'(ch_cnt_q) == (num_ch_q - NCH_W'(1)));
   assign pix_last  = (pix_cnt_q == (num_pix_q - PIX_W'(1)));
   assign cfg_hit   = cfg_we && !busy && ({1'b0, cfg_addr} < NCH_W'(CH_MAX));
   assign entry_cur = table_q[ch_cnt_q];

   // Next-state, counter and status decode
   always_comb begin
      state_d   = state_q;
      ch_cnt_d  = ch_cnt_q;
      pix_cnt_d = pix_cnt_q;
      num_ch_d  = num_ch_q;
      num_pix_d = num_pix_q;
      busy      = 1'b0;
      done      = 1'b0;
      acc_ready = 1'b0;
      beat      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_ch_d  = num_ch;
               num_pix_d = num_pix;
               ch_cnt_d  = '0;
               pix_cnt_d = '0;
               if ((num_ch == '0) || (num_ch > NCH_W'(CH_MAX)) || (num_pix == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            acc_ready = 1'b1;
            beat      = acc_valid;
            if (beat) begin
               if (ch_last) begin
                  ch_cnt_d  = '0;
                  pix_cnt_d = pix_cnt_q + PIX_W'(1);
                  if (pix_last) begin
                     state_d = S_DONE;
                  end
               end else begin
                  ch_cnt_d = ch_cnt_q + CH_AW'(1);
               end
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ch_cnt_q  <= '0;
         pix_cnt_q <= '0;
         num_ch_q  <= '0;
         num_pix_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_cnt_q  <= ch_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         num_ch_q  <= num_ch_d;
         num_pix_q <= num_pix_d;
      end
   end

   // Parameter table; reset clears it so a fresh load is required after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < CH_MAX; i++) begin
            table_q[i] <= '0;
         end
      end else if (cfg_hit) begin
         table_q[cfg_addr] <= '{m0: cfg_m0, index: cfg_index, zw: cfg_zw, z3: cfg_z3};
      end
   end

   // Output stage: word and its channel parameters land together; payload holds on idle cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_valid       <= 1'b0;
         q_serial32    <= '0;
         q_if_sum      <= 1'b0;
         q_M0          <= '0;
         q_index       <= '0;
         q_z_of_weight <= '0;
         q_z3          <= '0;
      end else begin
         q_valid <= beat;
         if (beat) begin
            q_serial32    <= acc_data;
            q_if_sum      <= acc_if_sum;
            q_M0          <= entry_cur.m0;
            q_index       <= entry_cur.index;
            q_z_of_weight <= entry_cur.zw;
            q_z3          <= entry_cur.z3;
         end
      end
   end

endmodule

// File: tb/tb_quan_param_sched.sv
// Directed bench for quan_param_sched: table of layer passes checked against a
// bench-side parameter model, plus hand-written reset and config corner cases.
module tb_quan_param_sched;

   localparam int unsigned CH_MAX = 16;
   localparam int unsigned CH_AW  = 4;
   localparam int unsigned PIX_W  = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_we;
   logic [CH_AW-1:0] cfg_addr;
   logic [31:0]      cfg_m0;
   logic [5:0]       cfg_index;
   logic [7:0]       cfg_zw;
   logic [7:0]       cfg_z3;
   logic             start;
   logic [CH_AW:0]   num_ch;
   logic [PIX_W-1:0] num_pix;
   logic             acc_valid;
   logic [31:0]      acc_data;
   logic             acc_if_sum;
   logic             acc_ready;
   logic             q_valid;
   logic [31:0]      q_serial32;
   logic             q_if_sum;
   logic [31:0]      q_M0;
   logic [5:0]       q_index;
   logic [7:0]       q_z_of_weight;
   logic [7:0]       q_z3;
   logic             busy;
   logic             done;

   quan_param_sched #(.CH_MAX(CH_MAX), .CH_AW(CH_AW), .PIX_W(PIX_W)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_m0(cfg_m0), .cfg_index(cfg_index),
      .cfg_zw(cfg_zw), .cfg_z3(cfg_z3),
      .start(start), .num_ch(num_ch), .num_pix(num_pix),
      .acc_valid(acc_valid), .acc_data(acc_data), .acc_if_sum(acc_if_sum),
      .acc_ready(acc_ready),
      .q_valid(q_valid), .q_serial32(q_serial32), .q_if_sum(q_if_sum),
      .q_M0(q_M0), .q_index(q_index), .q_z_of_weight(q_z_of_weight), .q_z3(q_z3),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [53:0] val;
   } cfg_vec_t;

   typedef struct {
      int nch;
      int npix;
      bit bubbles;
      bit poke;
      int exp_qv;
   } pass_vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [53:0] exp_tbl [CH_MAX];
   cfg_vec_t    cv [CH_MAX];
   pass_vec_t   pv [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] data_of(input int k);
      return 32'h100 * 32'(k + 1);
   endfunction

   // Called at a negedge; the write lands on the following posedge
   task automatic cfg_write(input int addr, input logic [53:0] v);
      cfg_we   = 1'b1;
      cfg_addr = CH_AW'(addr);
      {cfg_m0, cfg_index, cfg_zw, cfg_z3} = v;
      @(negedge clk);
      cfg_we = 1'b0;
      exp_tbl[addr] = v;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_q_valid"}, 64'(q_valid), 64'd0);
      chk({tag, "_q_data"}, 64'({q_serial32, q_if_sum}), 64'd0);
      chk({tag, "_q_params"}, 64'({q_M0, q_index, q_z_of_weight, q_z3}), 64'd0);
      chk({tag, "_status"}, 64'({busy, done, acc_ready}), 64'd0);
   endtask

   task automatic run_pass(input int nch, input int npix, input bit bubbles,
                           input bit poke, input int total);
      bit deg;
      int sent;
      int got;
      bit prev;
      bit phase;
      bit poked;
      bit finished;
      deg      = (nch == 0) || (nch > int'(CH_MAX)) || (npix == 0);
      sent     = 0;
      got      = 0;
      prev     = 1'b0;
      phase    = 1'b0;
      poked    = 1'b0;
      finished = 1'b0;
      start     = 1'b1;
      num_ch    = (CH_AW + 1)'(nch);
      num_pix   = PIX_W'(npix);
      acc_valid = deg;
      acc_data  = 32'hCAFE_0001;
      @(negedge clk);
      start = 1'b0;
      if (deg) begin
         chk("deg_done", 64'(done), 64'd1);
         chk("deg_busy", 64'(busy), 64'd1);
         chk("deg_ready", 64'(acc_ready), 64'd0);
         chk("deg_qv", 64'(q_valid), 64'd0);
         chk("deg_count", 64'(total), 64'd0);
         @(negedge clk);
         chk("deg_idle_status", 64'({busy, done, acc_ready}), 64'd0);
         chk("deg_idle_qv", 64'(q_valid), 64'd0);
         acc_valid = 1'b0;
         return;
      end
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         chk("q_valid_mirror", 64'(q_valid), 64'(prev));
         if (q_valid) begin
            chk("q_serial32", 64'(q_serial32), 64'(data_of(got)));
            chk("q_if_sum", 64'(q_if_sum), 64'(got[0]));
            chk("q_params", 64'({q_M0, q_index, q_z_of_weight, q_z3}), 64'(exp_tbl[got % nch]));
            got++;
         end
         if (prev && got == total) begin
            chk("done_last", 64'(done), 64'd1);
            chk("busy_last", 64'(busy), 64'd1);
            chk("ready_after_last", 64'(acc_ready), 64'd0);
            finished = 1'b1;
         end else begin
            chk("done_early", 64'(done), 64'd0);
            chk("ready_run", 64'({busy, acc_ready}), 64'd3);
         end
         if (poke && !poked && sent == 2 && !finished) begin
            cfg_we   = 1'b1;
            cfg_addr = '0;
            {cfg_m0, cfg_index, cfg_zw, cfg_z3} = '1;
            poked    = 1'b1;
         end else begin
            cfg_we = 1'b0;
         end
         if (finished) begin
            acc_valid = 1'b1;
            acc_data  = 32'hDEAD_BEEF;
            prev      = 1'b0;
         end else if (sent < total && !(bubbles && phase)) begin
            acc_valid  = 1'b1;
            acc_data   = data_of(sent);
            acc_if_sum = sent[0];
            prev       = 1'b1;
            sent++;
         end else begin
            acc_valid = 1'b0;
            prev      = 1'b0;
         end
         if (bubbles) phase = ~phase;
         @(negedge clk);
      end
      if (!finished) begin
         checks++;
         failures++;
         $display("FAIL pass_timeout: got %0d words expected %0d", got, total);
      end
      chk("idle_status", 64'({busy, done, acc_ready}), 64'd0);
      chk("idle_qv", 64'(q_valid), 64'd0);
      @(negedge clk);
      chk("idle_qv2", 64'(q_valid), 64'd0);
      acc_valid = 1'b0;
      cfg_we    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_m0 = '0; cfg_index = '0; cfg_zw = '0; cfg_z3 = '0;
      start = 1'b0; num_ch = '0; num_pix = '0;
      acc_valid = 1'b0; acc_data = '0; acc_if_sum = 1'b0;
      for (int i = 0; i < int'(CH_MAX); i++) exp_tbl[i] = '0;

      cv[0] = '{addr: 0, val: {32'h4000_0000, 6'd6, 8'd3, 8'd128}};
      cv[1] = '{addr: 1, val: {32'h2000_0000, 6'd7, 8'd0, 8'd10}};
      for (int i = 2; i < int'(CH_MAX); i++)
         cv[i] = '{addr: i, val: {32'h0100_0000 * 32'(i) + 32'(i), 6'(i + 8), 8'(i * 3), 8'(255 - i)}};

      pv[0] = '{nch: 2,  npix: 1, bubbles: 1'b0, poke: 1'b0, exp_qv: 2};
      pv[1] = '{nch: 3,  npix: 4, bubbles: 1'b0, poke: 1'b0, exp_qv: 12};
      pv[2] = '{nch: 3,  npix: 4, bubbles: 1'b1, poke: 1'b0, exp_qv: 12};
      pv[3] = '{nch: 3,  npix: 2, bubbles: 1'b0, poke: 1'b1, exp_qv: 6};
      pv[4] = '{nch: 1,  npix: 1, bubbles: 1'b0, poke: 1'b0, exp_qv: 1};
      pv[5] = '{nch: 16, npix: 1, bubbles: 1'b0, poke: 1'b0, exp_qv: 16};
      pv[6] = '{nch: 0,  npix: 3, bubbles: 1'b0, poke: 1'b0, exp_qv: 0};
      pv[7] = '{nch: 3,  npix: 0, bubbles: 1'b0, poke: 1'b0, exp_qv: 0};
      pv[8] = '{nch: 17, npix: 1, bubbles: 1'b0, poke: 1'b0, exp_qv: 0};

      #2 reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      for (int i = 0; i < int'(CH_MAX); i++) cfg_write(cv[i].addr, cv[i].val);

      for (int v = 0; v < 9; v++)
         run_pass(pv[v].nch, pv[v].npix, pv[v].bubbles, pv[v].poke, pv[v].exp_qv);

      // Entry rewritten the cycle before start must be used by the first beat on it
      cfg_write(2, {32'h7777_0002, 6'd33, 8'd44, 8'd55});
      run_pass(3, 1, 1'b0, 1'b0, 3);

      // Reset in the middle of a pass
      start = 1'b1; num_ch = 5'd3; num_pix = 16'd4;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         acc_valid = 1'b1; acc_data = data_of(k); acc_if_sum = 1'b0;
         @(negedge clk);
      end
      acc_valid = 1'b0;
      chk("pre_reset_qv", 64'(q_valid), 64'd1);
      reset = 1'b0;
      #1;
      check_all_zero("midpass_reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < int'(CH_MAX); i++) exp_tbl[i] = '0;
      @(negedge clk);
      check_all_zero("after_midpass_reset");
      run_pass(2, 1, 1'b0, 1'b0, 2);
      for (int i = 0; i < 3; i++) cfg_write(cv[i].addr, cv[i].val);
      run_pass(3, 4, 1'b0, 1'b0, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
